// File: rtl/life_scan.sv
// life_scan: raster scan sequencer for the Life cell array.
// Walks an X-by-Y grid one cell per clock, column first. It produces the
// per-frame generation-advance flag (single step or timed run) and a
// cursor-addressed single-cycle cell-flip pulse. Key inputs are plain
// levels; every key acts once per rising edge.
module life_scan #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_step,
  input  logic             key_run,
  input  logic             key_flip,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_up,
  input  logic             key_down,
  input  logic [PW-1:0]    period,
  output logic [LOG2X-1:0] col,
  output logic [LOG2Y-1:0] row,
  output logic             frame_end,
  output logic             nxt_bit,
  output logic             cell_flip,
  output logic             running,
  output logic [LOG2X-1:0] cur_x,
  output logic [LOG2Y-1:0] cur_y
);

  localparam logic [LOG2X-1:0] XMAX = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] YMAX = LOG2Y'(Y - 1);

  // Bit positions inside the packed key vector
  localparam int K_STEP  = 0;
  localparam int K_RUN   = 1;
  localparam int K_FLIP  = 2;
  localparam int K_LEFT  = 3;
  localparam int K_RIGHT = 4;
  localparam int K_UP    = 5;
  localparam int K_DOWN  = 6;
  localparam int KN      = 7;

  logic [KN-1:0]    keys;
  logic [KN-1:0]    key_s_q;
  logic [KN-1:0]    key_prev_q;
  logic [KN-1:0]    req;

  logic [LOG2X-1:0] col_q, col_d;
  logic [LOG2Y-1:0] row_q, row_d;
  logic             frame_end_q, frame_end_d;

  logic             running_q, running_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             timer_fire;

  logic             step_pend_q, step_pend_d;
  logic             step_set;
  logic             nxt_q, nxt_d;

  logic [LOG2X-1:0] cur_x_q, cur_x_d;
  logic [LOG2Y-1:0] cur_y_q, cur_y_d;

  logic             flip_pend_q, flip_pend_d;
  logic             flip_hit;

  assign keys = {key_down, key_up, key_right, key_left, key_flip, key_run, key_step};

  // Key sampling and history; both start at 1 so keys held through reset stay silent
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_s_q    <= '1;
      key_prev_q <= '1;
    end else begin
      key_s_q    <= keys;
      key_prev_q <= key_s_q;
    end
  end

  assign req = key_s_q & ~key_prev_q;

  // Scan position: column advances every cycle, row on column wrap
  always_comb begin
    col_d = col_q + LOG2X'(1);
    row_d = row_q;
    if (col_q == XMAX) begin
      col_d = '0;
      row_d = (row_q == YMAX) ? '0 : row_q + LOG2Y'(1);
    end
    // Registered flag that marks the last cell of the frame
    frame_end_d = (col_d == XMAX) && (row_d == YMAX);
  end

  // Run mode toggle and frame-period timer
  always_comb begin
    running_d  = running_q ^ req[K_RUN];
    timer_fire = running_q & frame_end_q & (cnt_q == period);
    cnt_d      = cnt_q;
    if (req[K_RUN] && !running_q) begin
      cnt_d = '0;
    end else if (running_q && frame_end_q) begin
      cnt_d = (cnt_q == period) ? '0 : cnt_q + PW'(1);
    end
  end

  // Step requests collect during the frame and are committed at its last cell
  always_comb begin
    step_set    = req[K_STEP] | timer_fire;
    nxt_d       = nxt_q;
    step_pend_d = step_pend_q | step_set;
    if (frame_end_q) begin
      nxt_d       = step_pend_q | step_set;
      step_pend_d = 1'b0;
    end
  end

  // Cursor movement with wrap; opposing keys on one axis cancel
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (req[K_LEFT] && !req[K_RIGHT]) begin
      cur_x_d = (cur_x_q == '0) ? XMAX : cur_x_q - LOG2X'(1);
    end else if (req[K_RIGHT] && !req[K_LEFT]) begin
      cur_x_d = (cur_x_q == XMAX) ? '0 : cur_x_q + LOG2X'(1);
    end
    if (req[K_UP] && !req[K_DOWN]) begin
      cur_y_d = (cur_y_q == '0) ? YMAX : cur_y_q - LOG2Y'(1);
    end else if (req[K_DOWN] && !req[K_UP]) begin
      cur_y_d = (cur_y_q == YMAX) ? '0 : cur_y_q + LOG2Y'(1);
    end
  end

  // Flip fires when the scan reaches the live cursor; decoded purely from registers
  always_comb begin
    flip_hit    = flip_pend_q && (col_q == cur_x_q) && (row_q == cur_y_q);
    flip_pend_d = flip_hit ? 1'b0 : (flip_pend_q | req[K_FLIP]);
  end

  // State registers for scan, run control, step, cursor and flip
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      frame_end_q <= 1'b0;
      running_q   <= 1'b0;
      cnt_q       <= '0;
      step_pend_q <= 1'b0;
      nxt_q       <= 1'b0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      flip_pend_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      frame_end_q <= frame_end_d;
      running_q   <= running_d;
      cnt_q       <= cnt_d;
      step_pend_q <= step_pend_d;
      nxt_q       <= nxt_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      flip_pend_q <= flip_pend_d;
    end
  end

  assign col       = col_q;
  assign row       = row_q;
  assign frame_end = frame_end_q;
  assign nxt_bit   = nxt_q;
  assign cell_flip = flip_hit;
  assign running   = running_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;

endmodule

// File: tb/tb_life_scan.sv
// Testbench for life_scan on a 5x3 grid. Stimulus pushes expected flip
// pulses and expected per-frame nxt_bit values into queues; a monitor
// pops and compares them when the DUT shows a pulse or a frame boundary.
module tb_life_scan;
  localparam int X = 5, Y = 3, LOG2X = 3, LOG2Y = 3, PW = 8;
  localparam int FL = X * Y;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, key_step, key_run, key_flip, key_left, key_right, key_up, key_down;
  logic [PW-1:0] period;
  logic [LOG2X-1:0] col, cur_x;
  logic [LOG2Y-1:0] row, cur_y;
  logic frame_end, nxt_bit, cell_flip, running;

  life_scan #(.X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .key_step(key_step), .key_run(key_run), .key_flip(key_flip),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .period(period),
    .col(col), .row(row), .frame_end(frame_end), .nxt_bit(nxt_bit),
    .cell_flip(cell_flip), .running(running), .cur_x(cur_x), .cur_y(cur_y)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  int base = 0;

  typedef struct { int c; int r; int t; } flip_t;
  flip_t flipq[$];
  int    nxtq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: flip pulses and frame-boundary nxt_bit checks
  flip_t mon_f;
  int    mon_exp = 0;
  bit    mon_have = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (cell_flip) begin
        if (flipq.size() == 0) chk("unexpected_flip", 1, 0);
        else begin
          mon_f = flipq.pop_front();
          chk("flip_col", int'(col), mon_f.c);
          chk("flip_row", int'(row), mon_f.r);
          chk("flip_cycle", cyc, mon_f.t);
        end
      end
      if (col == 0 && row == 0) begin
        if (nxtq.size() > 0) begin
          mon_exp  = nxtq.pop_front();
          mon_have = 1;
          chk("nxt_frame_start", int'(nxt_bit), mon_exp);
        end else mon_have = 0;
      end
      if (frame_end && mon_have) chk("nxt_frame_end", int'(nxt_bit), mon_exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int pos_now();
    return (cyc - base) % FL;
  endfunction

  task automatic goto_fp(input int f, input int p);
    int target = base + f * FL + p;
    int guard = 0;
    if (cyc > target) chk("goto_late", cyc, target);
    while (cyc < target && guard < 400) begin tick(1); guard++; end
  endtask

  task automatic goto_pos(input int p);
    int guard = 0;
    tick(1);
    while (pos_now() != p && guard < 40) begin tick(1); guard++; end
    if (pos_now() != p) chk("goto_pos_timeout", pos_now(), p);
  endtask

  task automatic press(input int which);
    case (which)
      0: key_left = 1'b1;
      1: key_right = 1'b1;
      2: key_up = 1'b1;
      3: key_down = 1'b1;
      default: begin key_left = 1'b1; key_right = 1'b1; end
    endcase
    tick(1);
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
    tick(3);
  endtask

  initial begin
    flip_t e;
    int t;
    reset = 1'b0; key_step = 1'b1; key_run = 1'b0; key_flip = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
    period = '0;

    // Reset state, with key_step held through reset
    tick(3);
    chk("rst_col", int'(col), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_frame_end", int'(frame_end), 0);
    chk("rst_nxt", int'(nxt_bit), 0);
    chk("rst_flip", int'(cell_flip), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_cur_x", int'(cur_x), 0);
    chk("rst_cur_y", int'(cur_y), 0);
    reset = 1'b1;
    base = cyc;

    // Three full frames of scan order; the held key must not cause a step
    for (int k = 0; k < 3 * FL; k++) begin
      chk("scan_col", int'(col), k % X);
      chk("scan_row", int'(row), (k / X) % Y);
      chk("scan_frame_end", int'(frame_end), (k % FL == FL - 1) ? 1 : 0);
      chk("scan_nxt", int'(nxt_bit), 0);
      if (k == 20) key_step = 1'b0;
      tick(1);
    end

    // Step held 3 cycles mid-frame 3 -> frame 4 computes, frame 5 does not
    goto_fp(3, 5);
    key_step = 1'b1;
    nxtq.push_back(1); nxtq.push_back(0);
    tick(3);
    key_step = 1'b0;

    // Step edge landing in the frame_end cycle of frame 5 -> frame 6
    goto_fp(5, 13);
    key_step = 1'b1;
    nxtq.push_back(1); nxtq.push_back(0);
    tick(1);
    chk("fe_at_last_cell", int'(frame_end), 1);
    key_step = 1'b0;

    // Run with period 2 from frame 7: generations in frames 10 and 13
    goto_fp(7, 2);
    period = 8'd2;
    key_run = 1'b1;
    nxtq.push_back(0); nxtq.push_back(0); nxtq.push_back(1);
    nxtq.push_back(0); nxtq.push_back(0); nxtq.push_back(1);
    tick(1);
    key_run = 1'b0;
    tick(2);
    chk("running_on", int'(running), 1);

    // Period 0: every frame; stop in frame 15 -> frames 16,17 idle
    goto_fp(13, 5);
    period = 8'd0;
    nxtq.push_back(1); nxtq.push_back(1); nxtq.push_back(0); nxtq.push_back(0);
    goto_fp(15, 5);
    key_run = 1'b1;
    tick(1);
    key_run = 1'b0;
    tick(3);
    chk("running_off", int'(running), 0);
    goto_fp(18, 1);

    // Cursor moves and wrap-around
    press(0); chk("left_wrap_x", int'(cur_x), 4);
    press(2); chk("up_wrap_y", int'(cur_y), 2);
    press(4); chk("left_right_x", int'(cur_x), 4);
    key_up = 1'b1; key_down = 1'b1; tick(1); key_up = 1'b0; key_down = 1'b0; tick(3);
    chk("up_down_y", int'(cur_y), 2);
    key_down = 1'b1; tick(20); key_down = 1'b0; tick(3);
    chk("held_down_y", int'(cur_y), 0);
    press(1); chk("right_wrap_x", int'(cur_x), 0);
    press(1); press(1); press(3);
    chk("cursor_x_2", int'(cur_x), 2);
    chk("cursor_y_1", int'(cur_y), 1);

    // Plain flip request at (2,1): scan position 7
    t = cyc + 2;
    while (((t - base) % FL) != 7) t++;
    e = '{2, 1, t};
    flipq.push_back(e);
    key_flip = 1'b1; tick(1); key_flip = 1'b0;
    tick(FL + 5);

    // Flip edge registered while the scan sits on the cursor -> next pass
    goto_pos(6);
    e = '{2, 1, cyc + 16};
    flipq.push_back(e);
    key_flip = 1'b1; tick(1); key_flip = 1'b0;
    tick(FL + 5);

    // Cursor moved up while flip pending -> lands at (2,0)
    goto_pos(8);
    e = '{2, 0, cyc + 9};
    flipq.push_back(e);
    key_flip = 1'b1; tick(1); key_flip = 1'b0;
    key_up = 1'b1; tick(1); key_up = 1'b0;
    tick(FL);
    chk("moved_cur_y", int'(cur_y), 0);

    // Reset mid-frame with a flip pending: no pulse afterwards
    goto_pos(5);
    key_flip = 1'b1; tick(1); key_flip = 1'b0;
    goto_pos(9);
    reset = 1'b0;
    tick(1);
    chk("midrst_col", int'(col), 0);
    chk("midrst_row", int'(row), 0);
    chk("midrst_flip", int'(cell_flip), 0);
    chk("midrst_cur_x", int'(cur_x), 0);
    tick(2);
    reset = 1'b1;
    base = cyc;
    tick(2 * FL + 10);
    chk("post_rst_col", int'(col), (2 * FL + 10) % X);

    chk("flip_queue_drained", flipq.size(), 0);
    chk("nxt_queue_drained", nxtq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
